// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern controller.
package led_pkg;

    localparam int unsigned SW_W = 2;

    typedef enum logic [SW_W-1:0] {
        MODE_ON    = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_COUNT = 2'd3
    } mode_e;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Synchronises a raw switch bus and only accepts a new value after it has
// been stable for DEB_CYCLES consecutive synchronised cycles.
module sw_debounce
    import led_pkg::*;
#(
    parameter int unsigned WIDTH      = 2,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] value,
    output logic             changed_c
);

    localparam int unsigned     CNT_W     = cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync_a;
    logic [WIDTH-1:0] sw_s;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] dcnt;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sw_s   <= '0;
        end else begin
            sync_a <= sw;
            sw_s   <= sync_a;
        end
    end

    // High in the cycle before value updates, so the consumer can act on the same edge.
    assign changed_c = (sw_s == cand) && (cand != value) && (dcnt == DCNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand  <= '0;
            dcnt  <= '0;
            value <= '0;
        end else if (sw_s != cand) begin
            cand <= sw_s;
            dcnt <= '0;
        end else if (cand != value) begin
            if (changed_c) begin
                value <= cand;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: debounced mode select, prescaled pattern stepping
// and global PWM brightness feeding a registered LED output.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned NUM_LED    = 3,
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          sw,
    input  logic [PWM_BITS-1:0] duty,
    output logic [NUM_LED-1:0]  led,
    output logic [1:0]          mode,
    output logic                tick
);

    localparam int unsigned         PCNT_W    = cnt_width(TICK_DIV);
    localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

    logic                mode_chg_c;
    logic [PCNT_W-1:0]   pcnt;
    logic [PCNT_W-1:0]   pcnt_nxt;
    logic                phase;
    logic [NUM_LED-1:0]  chase;
    logic [NUM_LED-1:0]  count;
    logic [NUM_LED-1:0]  pattern;
    logic [PWM_BITS-1:0] wcnt;
    logic [PWM_BITS-1:0] duty_q;
    logic                en_c;

    sw_debounce #(
        .WIDTH      (SW_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sw_debounce (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .value     (mode),
        .changed_c (mode_chg_c)
    );

    // Prescaler restarts on a mode change so the first step is a full period away.
    always_comb begin
        pcnt_nxt = pcnt + PCNT_W'(1);
        if (mode_chg_c || (pcnt == PCNT_LAST)) begin
            pcnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            pcnt <= pcnt_nxt;
            tick <= (pcnt_nxt == PCNT_LAST);
        end
    end

    // Step state; a mode change takes priority over a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            chase <= NUM_LED'(1);
            count <= '0;
        end else if (mode_chg_c) begin
            phase <= 1'b0;
            chase <= NUM_LED'(1);
            count <= '0;
        end else if (tick) begin
            phase <= ~phase;
            chase <= {chase[NUM_LED-2:0], chase[NUM_LED-1]};
            count <= count + NUM_LED'(1);
        end
    end

    always_comb begin
        pattern = '1;
        case (mode_e'(mode))
            MODE_ON:    pattern = '1;
            MODE_BLINK: pattern = phase ? '0 : '1;
            MODE_CHASE: pattern = chase;
            MODE_COUNT: pattern = count;
            default:    pattern = '1;
        endcase
    end

    // duty is sampled only at the period boundary to avoid mid-period glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt   <= '0;
            duty_q <= '1;
        end else begin
            wcnt <= wcnt + PWM_BITS'(1);
            if (wcnt == DUTY_FULL) begin
                duty_q <= duty;
            end
        end
    end

    assign en_c = (wcnt < duty_q) || (duty_q == DUTY_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '1;
        end else begin
            led <= pattern & {NUM_LED{en_c}};
        end
    end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Parametrised LED pattern controller: drives `NUM_LED` LEDs from a 2-bit switch mode select, with synchronised and debounced switches, four animated or static patterns, and global PWM brightness. It sits between the board switch inputs and the LED pins, and replaces single-cycle static switch-to-LED mapping. All outputs are registered.

## Interface
Parameters:
- `NUM_LED`, default 3: LED count, ≥2.
- `TICK_DIV`, default 25_000_000: clock cycles per pattern step, ≥2.
- `DEB_CYCLES`, default 1_000_000: consecutive stable synchronised-switch cycles required before a mode change, ≥1.
- `PWM_BITS`, default 4: brightness resolution, 1..8.

Ports:
- `clk`, in, 1: clock. Reset `rst`, asynchronous, active-high.
- `rst`, in, 1: async active-high reset.
- `sw`, in, 2: raw, asynchronous mode switches.
- `duty`, in, `PWM_BITS`: brightness, where 0 means dark and all-ones means full on.
- `led`, out, `NUM_LED`: LED drive. Reset value is all ones.
- `mode`, out, 2: current debounced mode. Reset value is 0.
- `tick`, out, 1: one-cycle pulse on each pattern step. Reset value is 0.

## Operation
- **Switch path**
  - `sw` passes through a 2-flop synchroniser to produce `sw_s`. The synchroniser resets to 0.
  - Candidate register `cand` and counter `dcnt`:
    - If `sw_s != cand`: `cand <= sw_s`, `dcnt <= 0`.
    - Else if `cand != mode`: when `dcnt == DEB_CYCLES-1`, `mode <= cand` and `dcnt <= 0`; otherwise `dcnt++`.
    - Else: hold.
- **Mode change**
  - The cycle `mode` updates, clear the prescaler, step state, and blink phase.
- **Prescaler**
  - `pcnt` counts 0..`TICK_DIV`-1 and wraps.
  - `tick` is 1 for the cycle where `pcnt == TICK_DIV-1`. The `tick` output is registered.
  - Step state advances on `tick` only.
- **Patterns**
  - 00 ON: all ones.
  - 01 BLINK: phase starts at 0 and toggles per tick. Pattern is all ones when phase = 0, else all zeros.
  - 10 CHASE: one-hot, starts at bit 0, rotates left per tick, and wraps from MSB to bit 0.
  - 11 COUNT: binary up-count, starts at 0, +1 per tick, modulo 2^`NUM_LED`.
- **PWM**
  - `wcnt` free-runs 0..2^`PWM_BITS`-1.
  - `duty_q` loads `duty` only when `wcnt` wraps to 0, so brightness changes are glitch-free. `duty_q` resets to all ones.
  - Enable `en = (wcnt < duty_q) || (duty_q == all ones)`.
- **Output**
  - `led <= pattern & {NUM_LED{en}}`.

## Timing
- Counting the first edge after a `sw` change as edge 1:
  - `sw_s` updates at edge 2.
  - `cand` updates at edge 3.
  - `mode` updates at edge `DEB_CYCLES+3`.
  - `led` shows the new pattern at edge `DEB_CYCLES+4`.
- A `sw_s` change before the count completes restarts debounce. `mode` does not change.
- Chase and count: the first step occurs `TICK_DIV` cycles after the mode change.
- Tick and mode change in the same cycle: the mode change wins, so the step is cleared, not advanced.
- A `duty` change takes effect at the next PWM period boundary. Worst-case delay is 2^`PWM_BITS` cycles.
- Reset mid-operation:
  - All registers return to reset values immediately.
  - `led` is all ones and `mode` is 0 regardless of `sw`.
  - After release, `sw` is re-debounced with the full latency above.

## Structure
- Package `led_pkg`:
  - Mode enum `MODE_ON`=0, `MODE_BLINK`=1, `MODE_CHASE`=2, `MODE_COUNT`=3.
  - Switch width constant `SW_W`=2.
- Sub-module `sw_debounce`, parametrised on width and `DEB_CYCLES`:
  - Contains the synchroniser, `cand`, and `dcnt`.
  - Outputs the debounced value plus a one-cycle `changed` strobe.
- The top level holds the prescaler, pattern generator, PWM, and output register.

## Test plan
All scenarios use `NUM_LED`=4, `TICK_DIV`=4, `DEB_CYCLES`=3, `PWM_BITS`=2, `duty`=3.
- **Reset:** assert `rst` async mid-cycle → `led`=1111, `mode`=00, `tick`=0 immediately, held while `rst`=1.
- **Chase:** `sw`=10 held → `mode`=10 at edge 6, `led`=0001 at edge 7, then 0010, 0100, 1000, 0001 every 4 cycles.
- **Glitch rejection:** `sw`=01 for 2 cycles then 00 → `mode` stays 00 and `led` stays 1111. Repeat with `sw`=01 held for 4 cycles → `mode`=01 with the full latency.
- **Count:** `mode`=11 → `led` 0000, 0001, … 1111, then 0000 after 16 ticks. The `tick` pulse period is 4 cycles.
- **PWM, ON mode:**
  - `duty`=2 → `led`=1111 for exactly 2 of every 4 cycles.
  - `duty`=0 → 0000 constantly.
  - `duty`=3 → 1111 constantly.
  - A `duty` change mid-period takes effect only after `wcnt` wraps.
- **Reset mid-chase:** pulse `rst` while `sw`=10 → `led`=1111 and `mode`=00. After release, `mode` returns to 10 at edge 6 and the chase restarts at 0001.
